mem_loader: RTL and testbench



---
 rtl/mem_loader.sv | 178 +++++++++++++++++
 tb/tb_mem_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// Serial program loader: byte stream (count, then little-endian words) into RAM words 0..n-1.
// Optional trailing XOR checksum byte when MEM_LOADER_CHECKSUM_EN is defined.
module mem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] wa,
    output logic [2:0]        wm,
    output logic [31:0]       wd,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_DATA, S_WRITE, S_SUM, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [1:0]        idx_q, idx_d;
    logic [23:0]       buf_q, buf_d;
    logic [31:0]       wd_q, wd_d;
    logic              rdy_q, rdy_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              xfer;
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
    logic              err_q, err_d;
`endif

    assign xfer = in_valid && rdy_q;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        words_d = words_q;
        addr_d  = addr_q;
        wa_d    = wa_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        wd_d    = wd_q;
`ifdef MEM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_COUNT;
                    addr_d  = '0;
                    words_d = '0;
`ifdef MEM_LOADER_CHECKSUM_EN
                    sum_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            S_COUNT: begin
                if (xfer) begin
                    // A zero count means a full RAM image.
                    n_d     = (in_data == 8'd0) ? {1'b1, {ADDR_W{1'b0}}}
                                                : (ADDR_W+1)'(in_data);
                    idx_d   = 2'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    idx_d = idx_q + 2'd1;
`ifdef MEM_LOADER_CHECKSUM_EN
                    sum_d = sum_q ^ in_data;
`endif
                    case (idx_q)
                        2'd0: buf_d[7:0]   = in_data;
                        2'd1: buf_d[15:8]  = in_data;
                        2'd2: buf_d[23:16] = in_data;
                        default: begin
                            wd_d    = {in_data, buf_q};
                            wa_d    = addr_q;
                            state_d = S_WRITE;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                words_d = words_q + 1'b1;
                if (words_d == n_q) begin
`ifdef MEM_LOADER_CHECKSUM_EN
                    state_d = S_SUM;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_DATA;
                end
            end
`ifdef MEM_LOADER_CHECKSUM_EN
            S_SUM: begin
                if (xfer) begin
                    err_d   = (in_data != sum_q);
                    state_d = S_DONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        rdy_d  = (state_d == S_COUNT) || (state_d == S_DATA) || (state_d == S_SUM);
        we_d   = (state_d == S_WRITE);
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            words_q <= '0;
            addr_q  <= '0;
            wa_q    <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            wd_q    <= '0;
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
            sum_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            words_q <= words_d;
            addr_q  <= addr_d;
            wa_q    <= wa_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            wd_q    <= wd_d;
            rdy_q   <= rdy_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MEM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
            err_q   <= err_d;
`endif
        end
    end

    assign in_ready = rdy_q;
    assign we       = we_q;
    assign wa       = wa_q;
    assign wm       = 3'b010;
    assign wd       = wd_q;
    assign busy     = busy_q;
    assign done     = done_q;
`ifdef MEM_LOADER_CHECKSUM_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: cycle table plus multi-cycle load sequences.
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        reset, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, we, busy, done, err;
    logic [7:0]  wa;
    logic [2:0]  wm;
    logic [31:0] wd;

    int checks = 0;
    int passes = 0;

    logic [7:0]  wq_a[$];
    logic [31:0] wq_d[$];
    logic [2:0]  wq_m[$];

    always #5 clk = ~clk;

    mem_loader #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .we(we), .wa(wa), .wm(wm),
        .wd(wd), .busy(busy), .done(done), .err(err)
    );

    always @(negedge clk) begin
        if (we === 1'b1) begin
            wq_a.push_back(wa);
            wq_d.push_back(wd);
            wq_m.push_back(wm);
        end
    end

    typedef struct {
        logic        rst, st, vld;
        logic [7:0]  dat;
        logic        rdy, we;
        logic [7:0]  wa;
        logic [31:0] wd;
        logic        busy, done;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic s, logic v, logic [7:0] d, logic rd,
                                logic w, logic [7:0] a, logic [31:0] x, logic b, logic dn);
        vec_t t;
        t.rst = r; t.st = s; t.vld = v; t.dat = d; t.rdy = rd;
        t.we = w; t.wa = a; t.wd = x; t.busy = b; t.done = dn;
        return t;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t = 0;
        if (gap) begin
            @(negedge clk);
            in_valid = 1'b0; in_data = 8'h5A;
        end
        @(negedge clk);
        in_valid = 1'b1; in_data = b;
        while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic load(input logic [31:0] words[$], input bit gap, input logic [7:0] bad);
        logic [7:0] x = 8'h00;
        logic [31:0] w;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        send_byte(8'(words.size()), gap);
        foreach (words[i]) begin
            w = words[i];
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8], gap);
                x = x ^ w[8*k +: 8];
            end
        end
`ifdef MEM_LOADER_CHECKSUM_EN
        send_byte(x ^ bad, gap);
`else
        x = bad;
`endif
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        while (done !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check(nm, {62'd0, done, busy}, {62'd0, 1'b1, 1'b0});
    endtask

    task automatic clear_q();
        wq_a.delete(); wq_d.delete(); wq_m.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ws[$];
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;

`ifndef MEM_LOADER_CHECKSUM_EN
        tbl.push_back(mk(1,0,0,8'h00, 0,0,8'h00,32'h0,        0,0));
        tbl.push_back(mk(0,1,0,8'h00, 1,0,8'h00,32'h0,        1,0));
        tbl.push_back(mk(0,0,1,8'h02, 1,0,8'h00,32'h0,        1,0));
        tbl.push_back(mk(0,0,1,8'h78, 1,0,8'h00,32'h0,        1,0));
        tbl.push_back(mk(0,0,1,8'h56, 1,0,8'h00,32'h0,        1,0));
        tbl.push_back(mk(0,0,1,8'h34, 1,0,8'h00,32'h0,        1,0));
        tbl.push_back(mk(0,0,1,8'h12, 0,1,8'h00,32'h12345678, 1,0));
        tbl.push_back(mk(0,0,1,8'hEF, 1,0,8'h00,32'h12345678, 1,0));
        tbl.push_back(mk(0,0,1,8'hEF, 1,0,8'h00,32'h12345678, 1,0));
        tbl.push_back(mk(0,0,1,8'hBE, 1,0,8'h00,32'h12345678, 1,0));
        tbl.push_back(mk(0,0,1,8'hAD, 1,0,8'h00,32'h12345678, 1,0));
        tbl.push_back(mk(0,0,1,8'hDE, 0,1,8'h01,32'hDEADBEEF, 1,0));
        tbl.push_back(mk(0,0,0,8'h00, 0,0,8'h01,32'hDEADBEEF, 0,1));
        tbl.push_back(mk(0,0,1,8'h55, 0,0,8'h01,32'hDEADBEEF, 0,1));
        tbl.push_back(mk(0,1,0,8'h00, 1,0,8'h01,32'hDEADBEEF, 1,0));
        tbl.push_back(mk(0,0,1,8'h01, 1,0,8'h01,32'hDEADBEEF, 1,0));
        tbl.push_back(mk(0,1,1,8'hAA, 1,0,8'h01,32'hDEADBEEF, 1,0));
        tbl.push_back(mk(0,0,1,8'hBB, 1,0,8'h01,32'hDEADBEEF, 1,0));
        tbl.push_back(mk(1,0,1,8'hCC, 0,0,8'h00,32'h0,        0,0));
        tbl.push_back(mk(0,0,0,8'h00, 0,0,8'h00,32'h0,        0,0));
        tbl.push_back(mk(0,1,0,8'h00, 1,0,8'h00,32'h0,        1,0));
        tbl.push_back(mk(0,0,1,8'h01, 1,0,8'h00,32'h0,        1,0));
        tbl.push_back(mk(0,0,1,8'hAA, 1,0,8'h00,32'h0,        1,0));
        tbl.push_back(mk(0,0,1,8'hBB, 1,0,8'h00,32'h0,        1,0));
        tbl.push_back(mk(0,0,1,8'hCC, 1,0,8'h00,32'h0,        1,0));
        tbl.push_back(mk(0,0,1,8'hDD, 0,1,8'h00,32'hDDCCBBAA, 1,0));
        tbl.push_back(mk(0,0,0,8'h00, 0,0,8'h00,32'hDDCCBBAA, 0,1));
        tbl.push_back(mk(0,1,0,8'h00, 1,0,8'h00,32'hDDCCBBAA, 1,0));
        tbl.push_back(mk(0,0,1,8'h01, 1,0,8'h00,32'hDDCCBBAA, 1,0));
        tbl.push_back(mk(0,0,1,8'h11, 1,0,8'h00,32'hDDCCBBAA, 1,0));
        tbl.push_back(mk(0,0,1,8'h22, 1,0,8'h00,32'hDDCCBBAA, 1,0));
        tbl.push_back(mk(0,0,1,8'h33, 1,0,8'h00,32'hDDCCBBAA, 1,0));
        tbl.push_back(mk(0,0,1,8'h44, 0,1,8'h00,32'h44332211, 1,0));
        tbl.push_back(mk(1,0,0,8'h00, 0,0,8'h00,32'h0,        0,0));
        tbl.push_back(mk(0,0,0,8'h00, 0,0,8'h00,32'h0,        0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; start = tbl[i].st;
            in_valid = tbl[i].vld; in_data = tbl[i].dat;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  64'({in_ready, we, wa, wd, busy, done, err, wm}),
                  64'({tbl[i].rdy, tbl[i].we, tbl[i].wa, tbl[i].wd,
                       tbl[i].busy, tbl[i].done, 1'b0, 3'b010}));
        end
`endif

        // Same two-word stream with valid low every other cycle.
        do_reset();
        clear_q();
        ws = '{32'h12345678, 32'hDEADBEEF};
        load(ws, 1'b1, 8'h00);
        wait_done("gap_done");
        check("gap_nwrites", 64'(wq_a.size()), 64'd2);
        if (wq_a.size() == 2) begin
            check("gap_w0", {21'd0, wq_m[0], wq_a[0], wq_d[0]}, {21'd0, 3'b010, 8'h00, 32'h12345678});
            check("gap_w1", {21'd0, wq_m[1], wq_a[1], wq_d[1]}, {21'd0, 3'b010, 8'h01, 32'hDEADBEEF});
        end
        check("gap_err", 64'(err), 64'd0);

        // Full-depth image: count byte 00 means 256 words.
        do_reset();
        clear_q();
        ws.delete();
        for (int i = 0; i < 256; i++) ws.push_back(32'(i));
        load(ws, 1'b0, 8'h00);
        wait_done("full_done");
        repeat (5) @(negedge clk);
        check("full_nwrites", 64'(wq_a.size()), 64'd256);
        if (wq_a.size() == 256) begin
            for (int i = 0; i < 256; i++)
                check($sformatf("full_w%0d", i), {21'd0, wq_m[i], wq_a[i], wq_d[i]},
                      {21'd0, 3'b010, 8'(i), 32'(i)});
        end
        check("full_last_wa", 64'(wa), 64'hFF);

`ifdef MEM_LOADER_CHECKSUM_EN
        do_reset();
        clear_q();
        ws = '{32'h08040201};
        load(ws, 1'b0, 8'h00);
        wait_done("sum_ok_done");
        check("sum_ok_err", 64'(err), 64'd0);
        clear_q();
        load(ws, 1'b0, 8'h01);
        wait_done("sum_bad_done");
        check("sum_bad_err", 64'(err), 64'd1);
        check("sum_bad_write", {32'(wq_a.size()), wq_d.size() > 0 ? wq_d[0] : 32'h0},
              {32'd1, 32'h08040201});
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
